// File: rtl/core_cmd_pkg.sv
// Shared definitions for the compute core command path: command layout,
// instruction codes and sequencer states.
package core_cmd_pkg;

  localparam int unsigned CMD_W   = 35;
  localparam int unsigned INS_W   = 5;
  localparam int unsigned OP_W    = 10;
  localparam int unsigned INS_LSB = 0;
  localparam int unsigned OP1_LSB = 5;
  localparam int unsigned OP2_LSB = 15;
  localparam int unsigned OP3_LSB = 25;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CLEAR} state_e;

  typedef logic [INS_W-1:0] ins_t;

  localparam ins_t INS_NOP     = 5'd0;
  localparam ins_t INS_TRNG    = 5'd18;
  localparam ins_t INS_AES_ENC = 5'd19;
  localparam ins_t INS_AES_DEC = 5'd20;
  localparam ins_t INS_PADD    = 5'd22;
  localparam ins_t INS_PSUB    = 5'd23;
  localparam ins_t INS_PMUL_LO = 5'd24;
  localparam ins_t INS_PMUL_HI = 5'd26;

  // Field order matches OP3_LSB/OP2_LSB/OP1_LSB/INS_LSB bit positions.
  typedef struct packed {
    logic [OP_W-1:0] op3;
    logic [OP_W-1:0] op2;
    logic [OP_W-1:0] op1;
    ins_t            ins;
  } cmd_t;

  // Same operands with INS forced to NOP; re-arms the engine's local reset.
  function automatic cmd_t nop_of(input cmd_t c);
    cmd_t r;
    r     = c;
    r.ins = INS_NOP;
    return r;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; extra pointer bit separates full from empty.
module cmd_fifo #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_level_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wptr;
  logic [LW-1:0]    r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_push & ~o_full_c;
  assign w_rd = i_pop & ~o_empty_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + LW'(1);
      if (w_rd) r_rptr <= r_rptr + LW'(1);
    end
  end

  // Storage needs no reset: pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_level_c = r_wptr - r_rptr;
  assign o_full_c  = (o_level_c == LW'(DEPTH));
  assign o_empty_c = (o_level_c == '0);
  assign o_rdata_c = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/compute_core_sequencer.sv
// Queues host commands and issues them to the compute core one at a time,
// following each with a NOP write so the engine re-arms between instructions.
module compute_core_sequencer
  import core_cmd_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 65535,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CMD_W-1:0]       cmd_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   enable,
  input  logic                   err_clear,
  output logic [CMD_W-1:0]       core_command,
  output logic                   core_we0,
  input  logic                   core_done,
  output logic                   busy,
  output logic [INS_W-1:0]       cur_ins,
  output logic [CNT_W-1:0]       done_count,
  output logic                   timeout_err,
  output logic [$clog2(DEPTH):0] fifo_level
);

  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned TN_W   = TCNT_W + 1;

  state_e            r_state;
  cmd_t              r_cur_cmd;
  cmd_t              r_core_command;
  logic              r_core_we0;
  logic              r_busy;
  ins_t              r_cur_ins;
  logic [CNT_W-1:0]  r_done_count;
  logic              r_timeout_err;
  logic [TCNT_W-1:0] r_tcnt;

  cmd_t              w_head;
  logic              w_full;
  logic              w_empty;
  logic [LW-1:0]     w_level;
  logic              w_push;
  logic              w_pop;
  logic              w_start;
  logic              w_done_ok;
  logic [TN_W-1:0]   w_tcnt_nxt;

  assign w_push     = cmd_valid & ~w_full;
  assign w_pop      = (r_state == IDLE) & enable & ~w_empty & ~r_timeout_err;
  assign w_start    = w_pop & (w_head.ins != INS_NOP);
  // The first WAIT cycle (tcnt==0) is a guard against a stale done level.
  assign w_done_ok  = core_done & (r_tcnt != '0);
  assign w_tcnt_nxt = {1'b0, r_tcnt} + TN_W'(1);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wdata   (cmd_in),
    .i_pop     (w_pop),
    .o_rdata_c (w_head),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_level_c (w_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cur_cmd      <= '0;
      r_core_command <= '0;
      r_core_we0     <= 1'b0;
      r_busy         <= 1'b0;
      r_cur_ins      <= INS_NOP;
      r_done_count   <= '0;
      r_timeout_err  <= 1'b0;
      r_tcnt         <= '0;
    end else begin
      // A timeout set later in this block overrides a same-cycle clear.
      if (err_clear) r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_core_we0 <= 1'b0;
          if (w_start) begin
            r_cur_cmd      <= w_head;
            r_core_command <= w_head;
            r_core_we0     <= 1'b1;
            r_busy         <= 1'b1;
            r_cur_ins      <= w_head.ins;
            r_state        <= ISSUE;
          end
        end
        ISSUE: begin
          r_core_we0 <= 1'b0;
          r_tcnt     <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (w_done_ok) begin
            r_done_count   <= r_done_count + CNT_W'(1);
            r_core_command <= nop_of(r_cur_cmd);
            r_core_we0     <= 1'b1;
            r_state        <= CLEAR;
          end else if (w_tcnt_nxt == TN_W'(TIMEOUT)) begin
            r_timeout_err  <= 1'b1;
            r_core_command <= nop_of(r_cur_cmd);
            r_core_we0     <= 1'b1;
            r_state        <= CLEAR;
          end else begin
            r_tcnt <= w_tcnt_nxt[TCNT_W-1:0];
          end
        end
        CLEAR: begin
          r_core_we0 <= 1'b0;
          r_busy     <= 1'b0;
          r_cur_ins  <= INS_NOP;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = ~w_full;
  assign fifo_level   = w_level;
  assign core_command = r_core_command;
  assign core_we0     = r_core_we0;
  assign busy         = r_busy;
  assign cur_ins      = r_cur_ins;
  assign done_count   = r_done_count;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_compute_core_sequencer.sv
// Directed bench for compute_core_sequencer with a simple latency-driven core model.
module tb_compute_core_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [34:0] cmd_in = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        enable = 1'b0;
  logic        err_clear = 1'b0;
  logic [34:0] core_command;
  logic        core_we0;
  logic        core_done = 1'b0;
  logic        busy;
  logic [4:0]  cur_ins;
  logic [15:0] done_count;
  logic        timeout_err;
  logic [4:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  // core model: 0 = done after latency, 1 = never done, 2 = done stuck high
  int core_mode = 0;
  int core_lat  = 10;
  int lat       = 0;

  logic [34:0] log_q[$];
  int          wait_cnt = 0;

  compute_core_sequencer #(
    .DEPTH   (16),
    .TIMEOUT (100),
    .CNT_W   (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_in       (cmd_in),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .enable       (enable),
    .err_clear    (err_clear),
    .core_command (core_command),
    .core_we0     (core_we0),
    .core_done    (core_done),
    .busy         (busy),
    .cur_ins      (cur_ins),
    .done_count   (done_count),
    .timeout_err  (timeout_err),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    core_done <= (core_mode == 2) || (core_mode == 0 && lat == 1);
    if (core_we0 && core_command[4:0] != 5'd0) lat <= core_lat;
    else if (lat > 0) lat <= lat - 1;
  end

  // Record every core write and count cycles spent in WAIT.
  always @(posedge clk) begin
    if (!rst && core_we0) log_q.push_back(core_command);
    if (!rst && busy && !core_we0) wait_cnt <= wait_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] mk(input logic [4:0] ins, input logic [9:0] op1,
                                     input logic [9:0] op2, input logic [9:0] op3);
    return {op3, op2, op1, ins};
  endfunction

  function automatic logic [34:0] nopw(input logic [34:0] c);
    return {c[34:5], 5'd0};
  endfunction

  task automatic push_cmd(input logic [34:0] c);
    cmd_in    = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done_count(input int target, input int limit, input string tag);
    int i;
    i = 0;
    while (done_count != 16'(target) && i < limit) begin tick(); i++; end
    check_eq(tag, 64'(done_count == 16'(target)), 64'd1);
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int i;
    i = 0;
    while (busy && i < limit) begin tick(); i++; end
    check_eq(tag, 64'(!busy), 64'd1);
  endtask

  task automatic wait_err(input int limit, input string tag);
    int i;
    i = 0;
    while (!timeout_err && i < limit) begin tick(); i++; end
    check_eq(tag, 64'(timeout_err), 64'd1);
  endtask

  task automatic wait_in_wait(input int limit, input string tag);
    int i;
    i = 0;
    while (!(busy && !core_we0) && i < limit) begin tick(); i++; end
    check_eq(tag, 64'(busy && !core_we0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_busy"}, 64'(busy), 64'd0);
    check_eq({pfx, "_we0"}, 64'(core_we0), 64'd0);
    check_eq({pfx, "_cmd"}, 64'(core_command), 64'd0);
    check_eq({pfx, "_cur_ins"}, 64'(cur_ins), 64'd0);
    check_eq({pfx, "_done_cnt"}, 64'(done_count), 64'd0);
    check_eq({pfx, "_terr"}, 64'(timeout_err), 64'd0);
    check_eq({pfx, "_ready"}, 64'(cmd_ready), 64'd1);
    check_eq({pfx, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    logic [34:0] padd, a_cmd, b_cmd, nop_cmd, pmul, extra;
    logic [34:0] exp_q[16];
    logic [4:0]  ins_tab[8];
    int          base, ws;

    ins_tab = '{5'd18, 5'd19, 5'd20, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single PADD: 2-cycle push-to-issue latency, issue + clear pulses
    padd   = mk(5'd22, 10'd0, 10'd32, 10'd64);
    enable = 1'b1;
    base   = log_q.size();
    push_cmd(padd);
    check_eq("padd_level1", 64'(fifo_level), 64'd1);
    check_eq("padd_no_we_yet", 64'(core_we0), 64'd0);
    tick();
    check_eq("padd_issue_we", 64'(core_we0), 64'd1);
    check_eq("padd_issue_cmd", 64'(core_command), 64'(padd));
    check_eq("padd_cur_ins", 64'(cur_ins), 64'd22);
    check_eq("padd_busy", 64'(busy), 64'd1);
    tick();
    check_eq("padd_we_pulse", 64'(core_we0), 64'd0);
    wait_idle(100, "padd_idle_timeout");
    check_eq("padd_writes", 64'(log_q.size() - base), 64'd2);
    check_eq("padd_log_issue", 64'(log_q[base]), 64'(padd));
    check_eq("padd_log_clear", 64'(log_q[base+1]), 64'(nopw(padd)));
    check_eq("padd_done_cnt", 64'(done_count), 64'd1);
    check_eq("padd_cur_ins_idle", 64'(cur_ins), 64'd0);

    // Fill FIFO with enable low, 17th push refused, then drain in order
    enable = 1'b0;
    base   = log_q.size();
    for (int i = 0; i < 16; i++) begin
      exp_q[i] = mk(ins_tab[i % 8], 10'(i * 7), 10'(i + 100), 10'(i * 3 + 1));
      push_cmd(exp_q[i]);
    end
    check_eq("fill_ready", 64'(cmd_ready), 64'd0);
    check_eq("fill_level", 64'(fifo_level), 64'd16);
    extra = mk(5'd22, 10'd1, 10'd2, 10'd3);
    push_cmd(extra);
    check_eq("fill_level_17", 64'(fifo_level), 64'd16);
    check_eq("fill_no_issue", 64'(log_q.size() - base), 64'd0);
    enable = 1'b1;
    wait_done_count(17, 3000, "fill_drain_timeout");
    wait_idle(50, "fill_idle_timeout");
    check_eq("fill_writes", 64'(log_q.size() - base), 64'd32);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("fill_issue_%0d", i), 64'(log_q[base + 2*i]), 64'(exp_q[i]));
      check_eq($sformatf("fill_clear_%0d", i), 64'(log_q[base + 2*i + 1]), 64'(nopw(exp_q[i])));
    end
    check_eq("fill_level_end", 64'(fifo_level), 64'd0);

    // Timeout: core never answers, error blocks the queue until cleared
    core_mode = 1;
    enable    = 1'b0;
    a_cmd     = mk(5'd18, 10'd5, 10'd6, 10'd7);
    b_cmd     = mk(5'd19, 10'd8, 10'd9, 10'd10);
    push_cmd(a_cmd);
    push_cmd(b_cmd);
    base    = log_q.size();
    ws      = wait_cnt;
    enable  = 1'b1;
    wait_err(500, "to_err_timeout");
    check_eq("to_wait_cycles", 64'(wait_cnt - ws), 64'd100);
    check_eq("to_clear_we", 64'(core_we0), 64'd1);
    check_eq("to_clear_cmd", 64'(core_command), 64'(nopw(a_cmd)));
    repeat (20) tick();
    check_eq("to_idle", 64'(busy), 64'd0);
    check_eq("to_held_level", 64'(fifo_level), 64'd1);
    check_eq("to_writes", 64'(log_q.size() - base), 64'd2);
    check_eq("to_done_cnt", 64'(done_count), 64'd17);
    check_eq("to_sticky", 64'(timeout_err), 64'd1);
    core_mode = 0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    check_eq("to_cleared", 64'(timeout_err), 64'd0);
    wait_done_count(18, 200, "to_resume_timeout");
    check_eq("to_resume_cmd", 64'(log_q[base+2]), 64'(b_cmd));
    wait_idle(50, "to_idle_timeout");

    // NOP in the queue is discarded without a core write
    enable  = 1'b0;
    nop_cmd = mk(5'd0, 10'd11, 10'd12, 10'd13);
    pmul    = mk(5'd24, 10'd14, 10'd15, 10'd16);
    push_cmd(nop_cmd);
    push_cmd(pmul);
    base   = log_q.size();
    enable = 1'b1;
    wait_done_count(19, 200, "nop_done_timeout");
    wait_idle(50, "nop_idle_timeout");
    check_eq("nop_writes", 64'(log_q.size() - base), 64'd2);
    check_eq("nop_pmul_issue", 64'(log_q[base]), 64'(pmul));
    check_eq("nop_level", 64'(fifo_level), 64'd0);

    // Done stuck high: guard cycle forces exactly two WAIT cycles each
    core_mode = 2;
    tick();
    ws = wait_cnt;
    push_cmd(mk(5'd23, 10'd1, 10'd1, 10'd1));
    push_cmd(mk(5'd25, 10'd2, 10'd2, 10'd2));
    wait_done_count(21, 200, "stuck_done_timeout");
    wait_idle(50, "stuck_idle_timeout");
    repeat (3) tick();
    check_eq("stuck_done_cnt", 64'(done_count), 64'd21);
    check_eq("stuck_wait_cycles", 64'(wait_cnt - ws), 64'd4);

    // Reset mid-WAIT with entries queued
    core_mode = 1;
    enable    = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(mk(5'd26, 10'(i), 10'(i), 10'(i)));
    enable = 1'b1;
    wait_in_wait(50, "rst_wait_timeout");
    check_eq("rst_pre_level", 64'(fifo_level), 64'd3);
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) tick();
    check_eq("midrst_after_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
